// File: rtl/tff_bank_counter.sv
// ---------------------------------------------------------------------------
// tff_bank_counter
//
// WIDTH-bit bank of T flip-flops. It works either as a raw per-bit toggle
// bank or as a modulo-MODULUS up/down counter with a synchronous, clamped
// load. The true output, the complement output and the terminal-count pulse
// all come straight from registers.
//
// Ports
//   clk       in   1      rising-edge clock for all state
//   rst       in   1      synchronous active-high reset (highest priority)
//   en        in   1      advance enable; load still acts when low
//   mode      in   2      00 toggle-bank, 01 up, 10 down, 11 hold
//   t_in      in   WIDTH  per-bit toggle requests (mode 00 only)
//   load      in   1      synchronous load strobe (beats en/mode)
//   load_val  in   WIDTH  load value, clamped to MODULUS-1
//   q         out  WIDTH  registered state
//   qb        out  WIDTH  registered complement of q
//   tc        out  1      registered terminal-count / all-ones pulse
//
// Parameters
//   WIDTH    1..32
//   MODULUS  2..2**WIDTH (64-bit so that 2**32 can be expressed)
// ---------------------------------------------------------------------------
module tff_bank_counter #(
  parameter int              WIDTH   = 8,
  parameter longint unsigned MODULUS = 64'd1 << WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] t_in,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             tc
);

  typedef enum logic [1:0] {
    MODE_TOGGLE = 2'b00,
    MODE_UP     = 2'b01,
    MODE_DOWN   = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_e;

  // Largest value the counter modes may hold. Every comparison against the
  // modulus is expressed through this constant so that all arithmetic stays
  // WIDTH bits wide, including the MODULUS = 2**WIDTH case.
  localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MODULUS - 64'd1);
  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] ZERO     = '0;

  logic [WIDTH-1:0] cnt_q,  cnt_d;
  logic [WIDTH-1:0] cntb_q;
  logic             tc_q,   tc_d;

  logic [WIDTH-1:0] toggled;
  logic [WIDTH-1:0] load_clamped;
  logic             toggled_all_ones;
  logic             cnt_all_ones;
  logic             cnt_at_or_above_max;
  logic             cnt_above_max;
  logic             cnt_is_zero;
  mode_e            mode_sel;

  assign mode_sel = mode_e'(mode);

  // One T flip-flop per bit: each bit flips independently when requested.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_tff
      assign toggled[gi] = cnt_q[gi] ^ t_in[gi];
    end
  endgenerate

  // load_val >= MODULUS is the same test as load_val > MODULUS-1, and the
  // second form never needs a WIDTH+1-bit constant.
  assign load_clamped        = (load_val > MAX_VAL) ? MAX_VAL : load_val;

  assign toggled_all_ones    = (toggled == ALL_ONES);
  assign cnt_all_ones        = (cnt_q == ALL_ONES);
  assign cnt_at_or_above_max = (cnt_q >= MAX_VAL);
  assign cnt_above_max       = (cnt_q > MAX_VAL);
  assign cnt_is_zero         = (cnt_q == ZERO);

  // Next-state and next-pulse logic. Priority: load > (en, mode) > hold.
  // Reset sits above all of this in the register process.
  always_comb begin
    cnt_d = cnt_q;
    tc_d  = 1'b0;
    if (load) begin
      cnt_d = load_clamped;
    end else if (en) begin
      unique case (mode_sel)
        MODE_TOGGLE: begin
          cnt_d = toggled;
          // Pulse only on the edge that arrives at all ones, not while
          // the bank simply stays there.
          tc_d  = toggled_all_ones && !cnt_all_ones;
        end
        MODE_UP: begin
          if (cnt_at_or_above_max) begin
            cnt_d = ZERO;
            tc_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        MODE_DOWN: begin
          if (cnt_is_zero) begin
            cnt_d = MAX_VAL;
            tc_d  = 1'b1;
          end else if (cnt_above_max) begin
            // Only reachable after toggle mode left the bank above the
            // modulus: pull back into range without a wrap pulse.
            cnt_d = MAX_VAL;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        MODE_HOLD: begin
          cnt_d = cnt_q;
        end
        default: begin
          cnt_d = cnt_q;
        end
      endcase
    end
  end

  // The complement is held in its own register, loaded from the same
  // next-state value, so qb is glitch-free and lines up exactly with q.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= ZERO;
      cntb_q <= ALL_ONES;
      tc_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      cntb_q <= ~cnt_d;
      tc_q   <= tc_d;
    end
  end

  assign q  = cnt_q;
  assign qb = cntb_q;
  assign tc = tc_q;

endmodule
